// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice per clock, LSB slice first,
// with the ripple carry kept in a register between slices.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  int               sliceBase;
  logic [DIGIT-1:0] aSlice, bSlice;
  logic [DIGIT:0]   sliceSum;
  logic             lastDigit, carryIntoMsb, accept;

  // b_q already holds the effective operand (inverted for subtract), so the
  // datapath is a plain adder and sub/cin only matter at load time.
  assign sliceBase    = int'(cnt_q) * DIGIT;
  assign aSlice       = a_q[sliceBase +: DIGIT];
  assign bSlice       = b_q[sliceBase +: DIGIT];
  assign sliceSum     = {1'b0, aSlice} + {1'b0, bSlice} + (DIGIT+1)'(carry_q);
  assign carryIntoMsb = aSlice[DIGIT-1] ^ bSlice[DIGIT-1] ^ sliceSum[DIGIT-1];
  assign lastDigit    = (cnt_q == LAST);
  assign accept       = start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        sum_d[sliceBase +: DIGIT] = sliceSum[DIGIT-1:0];
        carry_d = sliceSum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (lastDigit) begin
          state_d = DONE;
          cnt_d   = '0;
          cout_d  = sliceSum[DIGIT];
          ovf_d   = carryIntoMsb ^ sliceSum[DIGIT];
          zero_d  = (sum_d == '0);
        end
      end
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub ? 1'b1 : cin;
      cnt_d   = '0;
      sum_d   = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
      zero_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: three instances (16/4, 4/1, 8/8) checked every
// cycle against an arithmetic model, plus directed literal expectations.
module tb_digit_serial_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start16 = 0, sub16 = 0, cin16 = 0;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        cout16, ovf16, zero16, busy16, done16;
  logic        start4 = 0, sub4 = 0, cin4 = 0;
  logic [3:0]  a4 = '0, b4 = '0, sum4;
  logic        cout4, ovf4, zero4, busy4, done4;
  logic        start8 = 0, sub8 = 0, cin8 = 0;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        cout8, ovf8, zero8, busy8, done8;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16), .cin(cin16),
    .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16), .busy(busy16), .done(done16));
  digit_serial_adder #(.WIDTH(4), .DIGIT(1)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
    .sum(sum4), .cout(cout4), .ovf(ovf4), .zero(zero4), .busy(busy4), .done(done4));
  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8), .busy(busy8), .done(done8));

  int errors = 0;
  int checks = 0;
  bit checking = 0;
  int widthOf[3] = '{16, 4, 8};
  int ndigOf[3]  = '{4, 4, 1};

  int   mLeft[3];
  bit   mDone[3];
  res_t mOut[3];
  res_t mPend[3];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Result straight from the arithmetic definition; overflow from operand/result signs.
  function automatic res_t computeResult(input int w, input logic [31:0] av, input logic [31:0] bv,
                                         input logic s, input logic c);
    res_t r;
    longint unsigned mask, ae, be, tot;
    bit sa, sb, ss;
    mask   = (64'd1 << w) - 64'd1;
    ae     = {32'd0, av} & mask;
    be     = (s ? {32'd0, ~bv} : {32'd0, bv}) & mask;
    tot    = ae + be + (s ? 64'd1 : {63'd0, c});
    r.sum  = 32'(tot & mask);
    r.cout = ((tot >> w) & 64'd1) != 0;
    sa     = ((ae >> (w - 1)) & 64'd1) != 0;
    sb     = ((be >> (w - 1)) & 64'd1) != 0;
    ss     = ((tot >> (w - 1)) & 64'd1) != 0;
    r.ovf  = (sa == sb) && (ss != sa);
    r.zero = (r.sum == 32'd0);
    return r;
  endfunction

  function automatic logic getStart(input int id);
    case (id)
      0: return start16;
      1: return start4;
      default: return start8;
    endcase
  endfunction

  function automatic res_t getOpsResult(input int id);
    case (id)
      0: return computeResult(16, 32'(a16), 32'(b16), sub16, cin16);
      1: return computeResult(4, 32'(a4), 32'(b4), sub4, cin4);
      default: return computeResult(8, 32'(a8), 32'(b8), sub8, cin8);
    endcase
  endfunction

  function automatic logic [31:0] getSum(input int id);
    case (id)
      0: return 32'(sum16);
      1: return 32'(sum4);
      default: return 32'(sum8);
    endcase
  endfunction

  // {cout, ovf, zero, busy, done}
  function automatic logic [4:0] getFlags(input int id);
    case (id)
      0: return {cout16, ovf16, zero16, busy16, done16};
      1: return {cout4, ovf4, zero4, busy4, done4};
      default: return {cout8, ovf8, zero8, busy8, done8};
    endcase
  endfunction

  task automatic driveInputs(input int id, input logic st, input logic s, input logic [31:0] av,
                             input logic [31:0] bv, input logic c);
    case (id)
      0: begin start16 = st; sub16 = s; a16 = av[15:0]; b16 = bv[15:0]; cin16 = c; end
      1: begin start4 = st; sub4 = s; a4 = av[3:0]; b4 = bv[3:0]; cin4 = c; end
      default: begin start8 = st; sub8 = s; a8 = av[7:0]; b8 = bv[7:0]; cin8 = c; end
    endcase
  endtask

  // Model: an accepted start yields the result NDIG edges later, with done for one cycle.
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        mLeft[k] = 0;
        mDone[k] = 0;
        mOut[k]  = '0;
      end else if (mLeft[k] > 0) begin
        mLeft[k]--;
        if (mLeft[k] == 0) begin
          mDone[k] = 1;
          mOut[k]  = mPend[k];
        end
      end else begin
        mDone[k] = 0;
        if (getStart(k)) begin
          mPend[k] = getOpsResult(k);
          mLeft[k] = ndigOf[k];
          mOut[k]  = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int k = 0; k < 3; k++) begin
        logic [4:0] f;
        f = getFlags(k);
        checkOutput($sformatf("busy[%0d]", k), 32'(f[1]), 32'(mLeft[k] > 0));
        checkOutput($sformatf("done[%0d]", k), 32'(f[0]), 32'(mDone[k]));
        if (mLeft[k] == 0) begin
          checkOutput($sformatf("sum[%0d]", k), getSum(k), mOut[k].sum);
          checkOutput($sformatf("cout[%0d]", k), 32'(f[4]), 32'(mOut[k].cout));
          checkOutput($sformatf("ovf[%0d]", k), 32'(f[3]), 32'(mOut[k].ovf));
          checkOutput($sformatf("zero[%0d]", k), 32'(f[2]), 32'(mOut[k].zero));
        end
      end
    end
  end

  // Issues one start, scrambles the operands afterwards and waits (bounded) for done.
  task automatic applyStimulus(input int id, input bit noWait, input logic s, input logic [31:0] av,
                               input logic [31:0] bv, input logic c, output int lat, output int busyCnt);
    logic [4:0] f;
    if (!noWait) @(negedge clk);
    driveInputs(id, 1'b1, s, av, bv, c);
    @(negedge clk);
    driveInputs(id, 1'b0, ~s, ~av, ~bv, ~c);
    lat = 0;
    busyCnt = 0;
    f = getFlags(id);
    while (!f[0] && lat < 40) begin
      busyCnt += int'(f[1]);
      @(negedge clk);
      lat++;
      f = getFlags(id);
    end
    if (!f[0]) checkOutput($sformatf("timeout[%0d]", id), 32'(f[0]), 32'd1);
  endtask

  task automatic runAndCheck(input string name, input int id, input bit noWait, input logic s,
                             input logic [31:0] av, input logic [31:0] bv, input logic c,
                             input logic [31:0] expSum, input logic expCout, input logic expOvf,
                             input logic expZero, input int expLat);
    int lat, busyCnt;
    logic [4:0] f;
    applyStimulus(id, noWait, s, av, bv, c, lat, busyCnt);
    f = getFlags(id);
    checkOutput({name, ".sum"}, getSum(id), expSum);
    checkOutput({name, ".cout"}, 32'(f[4]), 32'(expCout));
    checkOutput({name, ".ovf"}, 32'(f[3]), 32'(expOvf));
    checkOutput({name, ".zero"}, 32'(f[2]), 32'(expZero));
    checkOutput({name, ".latency"}, 32'(lat), 32'(expLat));
    checkOutput({name, ".busyCycles"}, 32'(busyCnt), 32'(expLat));
  endtask

  initial begin
    int lat, busyCnt, doneCount;
    bit first;
    logic [31:0] heldSum;

    #1 rst = 1'b1;
    #1;
    checkOutput("reset.sum", getSum(0), 32'd0);
    checkOutput("reset.flags16", 32'(getFlags(0)), 32'd0);
    checkOutput("reset.flags4", 32'(getFlags(1)), 32'd0);
    checkOutput("reset.flags8", 32'(getFlags(2)), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checking = 1;

    runAndCheck("ffff+1", 0, 0, 0, 32'hFFFF, 32'h0001, 0, 32'h0000, 1, 0, 1, 4);
    runAndCheck("7fff+1", 0, 0, 0, 32'h7FFF, 32'h0001, 0, 32'h8000, 0, 1, 0, 4);
    runAndCheck("5-7", 0, 0, 1, 32'h0005, 32'h0007, 1, 32'hFFFE, 0, 0, 0, 4);
    repeat (3) @(negedge clk);
    checkOutput("hold.sum", getSum(0), 32'hFFFE);

    // Second start lands in the second RUN cycle and must be ignored.
    @(negedge clk);
    driveInputs(0, 1, 0, 32'h1234, 32'h0FFF, 0);
    @(negedge clk);
    driveInputs(0, 0, 0, 32'h1234, 32'h0FFF, 0);
    @(negedge clk);
    driveInputs(0, 1, 0, 32'hAAAA, 32'h5555, 1);
    @(negedge clk);
    driveInputs(0, 0, 0, 32'h0000, 32'h0000, 0);
    doneCount = 0;
    heldSum = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done16) begin
        doneCount++;
        heldSum = 32'(sum16);
      end
    end
    checkOutput("ignoredStart.doneCount", 32'(doneCount), 32'd1);
    checkOutput("ignoredStart.sum", heldSum, 32'h2233);

    // Reset in the middle of RUN aborts the operation.
    @(negedge clk);
    driveInputs(0, 1, 0, 32'h4321, 32'h1111, 0);
    @(negedge clk);
    driveInputs(0, 0, 0, 32'h4321, 32'h1111, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midReset.sum", getSum(0), 32'd0);
    checkOutput("midReset.flags", 32'(getFlags(0)), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done16) doneCount++;
    end
    checkOutput("midReset.noDone", 32'(doneCount), 32'd0);
    runAndCheck("1234+1111", 0, 0, 0, 32'h1234, 32'h1111, 0, 32'h2345, 0, 0, 0, 4);

    // Single-slice configuration, including back-to-back starts.
    runAndCheck("80+80", 2, 0, 0, 32'h80, 32'h80, 0, 32'h00, 1, 1, 1, 1);
    runAndCheck("10-20", 2, 1, 1, 32'h10, 32'h20, 1, 32'hF0, 0, 0, 0, 1);
    runAndCheck("7f+1+1", 2, 1, 0, 32'h7F, 32'h01, 1, 32'h81, 0, 1, 0, 1);

    // Exhaustive 4-bit sweep, each operation started in the previous DONE cycle.
    first = 1;
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++)
        for (int x = 0; x < 16; x++)
          for (int y = 0; y < 16; y++) begin
            applyStimulus(1, !first, 1'(s), 32'(x), 32'(y), 1'(c), lat, busyCnt);
            first = 0;
            checkOutput("sweep.latency", 32'(lat), 32'd4);
          end
    runAndCheck("9+6+1", 1, 1, 0, 32'h9, 32'h6, 1, 32'h0, 1, 0, 1, 4);
    runAndCheck("3-5", 1, 1, 1, 32'h3, 32'h5, 0, 32'hE, 0, 0, 0, 4);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
